// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage: FSM states, default
// widths, the MEM/WB bubble control value and the alignment helper.
package mem_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_REG_W  = 5;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } memState_t;

  // Write-back control fields carried through MEM/WB.
  typedef struct packed {
    logic memToReg;
    logic regWrite;
  } wbCtrl_t;

  // A bubble must never write the register file.
  localparam wbCtrl_t WB_BUBBLE = '{memToReg: 1'b0, regWrite: 1'b0};

  // Word accesses only: the two low address bits must be zero.
  function automatic logic isAligned(input logic [1:0] lowBits);
    return (lowBits == 2'b00);
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus. The stage is the master; memory is the slave.
// memRdata is valid in the same cycle as memAck.
interface mem_access_stage_if
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);

  logic              memReq;
  logic              memWe;
  logic [DATA_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              memAck;
  logic [DATA_W-1:0] memRdata;

  modport master (
    output memReq, memWe, memAddr, memWdata,
    input  memAck, memRdata
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata,
    output memAck, memRdata
  );

endinterface

// File: rtl/mem_wb.sv
// MEM/WB pipeline register. Synchronous reset; loadBubble clears every
// field so that write-back sees a harmless no-op.
module mem_wb
  import mem_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_W  = DEF_REG_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              loadBubble,
  input  logic [DATA_W-1:0] inReadData,
  input  logic [DATA_W-1:0] inResult,
  input  logic              inMemToReg,
  input  logic              inRegWrite,
  input  logic [REG_W-1:0]  inWriteRegister,
  output logic [DATA_W-1:0] outReadData,
  output logic [DATA_W-1:0] outResult,
  output logic              outMemToReg,
  output logic              outRegWrite,
  output logic [REG_W-1:0]  outWriteRegister
);

  // Capture the stage result, or a bubble, every cycle.
  always_ff @(posedge clock) begin
    if (reset || loadBubble) begin
      outReadData                 <= {DATA_W{1'b0}};
      outResult                   <= {DATA_W{1'b0}};
      {outMemToReg, outRegWrite}  <= WB_BUBBLE;
      outWriteRegister            <= {REG_W{1'b0}};
    end else begin
      outReadData      <= inReadData;
      outResult        <= inResult;
      outMemToReg      <= inMemToReg;
      outRegWrite      <= inRegWrite;
      outWriteRegister <= inWriteRegister;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage. Issues loads/stores on the req/ack bus,
// stalls upstream while an access is outstanding and feeds MEM/WB.
// Optional feature: define MEM_TIMEOUT_EN to abort accesses that wait
// TIMEOUT_CYCLES busy cycles without an ack (memError then pulses).
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int DATA_W         = DEF_DATA_W,
  parameter int REG_W          = DEF_REG_W,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [DATA_W-1:0]    inResult,
  input  logic [DATA_W-1:0]    inReadRegister2,
  input  logic                 inMemRead,
  input  logic                 inMemWrite,
  input  logic                 inMemToReg,
  input  logic                 inRegWrite,
  input  logic [REG_W-1:0]     inWriteRegister,
  mem_access_stage_if.master   memBus,
  output logic                 stall,
  output logic [DATA_W-1:0]    outReadData,
  output logic [DATA_W-1:0]    outResult,
  output logic                 outMemToReg,
  output logic                 outRegWrite,
  output logic [REG_W-1:0]     outWriteRegister,
  output logic                 memMisalign,
  output logic                 memError
);

  memState_t         state_r, nextState_s;
  logic [DATA_W-1:0] busyAddr_r, busyWdata_r;
  logic              busyWe_r, busyMemToReg_r, busyRegWrite_r;
  logic [REG_W-1:0]  busyWriteRegister_r;
  logic              misalign_r, error_r;

  logic              isMem_s, aligned_s, latch_s, misalign_s, abort_s, timeoutHit_s;
  logic              wbBubble_s, wbMemToReg_s, wbRegWrite_s;
  logic [DATA_W-1:0] wbReadData_s, wbResult_s;
  logic [REG_W-1:0]  wbWriteRegister_s;

  assign isMem_s   = inMemRead | inMemWrite;
  assign aligned_s = isAligned(inResult[1:0]);

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] waitCnt_r;

  // Count busy cycles without ack; cleared whenever a new access enters BUSY.
  always_ff @(posedge clock) begin
    if (reset || latch_s) begin
      waitCnt_r <= {CNT_W{1'b0}};
    end else if (state_r == BUSY && !memBus.memAck) begin
      waitCnt_r <= waitCnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      waitCnt_r <= waitCnt_r;
    end
  end

  // This busy cycle would bring the count to the limit.
  assign timeoutHit_s = (waitCnt_r == WAIT_LAST);
`else
  assign timeoutHit_s = 1'b0;
`endif

  // Next state, bus drive and MEM/WB input selection.
  always_comb begin
    nextState_s        = state_r;
    memBus.memReq      = 1'b0;
    memBus.memWe       = 1'b0;
    memBus.memAddr     = {DATA_W{1'b0}};
    memBus.memWdata    = {DATA_W{1'b0}};
    latch_s            = 1'b0;
    misalign_s         = 1'b0;
    abort_s            = 1'b0;
    wbBubble_s         = 1'b0;
    wbReadData_s       = {DATA_W{1'b0}};
    wbResult_s         = inResult;
    wbMemToReg_s       = inMemToReg;
    wbRegWrite_s       = inRegWrite;
    wbWriteRegister_s  = inWriteRegister;
    case (state_r)
      IDLE: begin
        if (isMem_s && aligned_s) begin
          memBus.memReq   = 1'b1;
          memBus.memWe    = inMemWrite;
          memBus.memAddr  = {inResult[DATA_W-1:2], 2'b00};
          memBus.memWdata = inReadRegister2;
          if (memBus.memAck) begin
            wbReadData_s = inMemWrite ? {DATA_W{1'b0}} : memBus.memRdata;
          end else begin
            nextState_s = BUSY;
            latch_s     = 1'b1;
            wbBubble_s  = 1'b1;
          end
        end else if (isMem_s) begin
          misalign_s = 1'b1;
          wbBubble_s = 1'b1;
        end else begin
          wbReadData_s = {DATA_W{1'b0}};
        end
      end
      BUSY: begin
        memBus.memReq     = 1'b1;
        memBus.memWe      = busyWe_r;
        memBus.memAddr    = {busyAddr_r[DATA_W-1:2], 2'b00};
        memBus.memWdata   = busyWdata_r;
        wbResult_s        = busyAddr_r;
        wbMemToReg_s      = busyMemToReg_r;
        wbRegWrite_s      = busyRegWrite_r;
        wbWriteRegister_s = busyWriteRegister_r;
        if (memBus.memAck) begin
          wbReadData_s = busyWe_r ? {DATA_W{1'b0}} : memBus.memRdata;
          nextState_s  = IDLE;
        end else begin
          wbBubble_s = 1'b1;
          if (timeoutHit_s) begin
            abort_s     = 1'b1;
            nextState_s = IDLE;
          end else begin
            nextState_s = BUSY;
          end
        end
      end
      default: begin
        nextState_s = IDLE;
        wbBubble_s  = 1'b1;
      end
    endcase
  end

  assign stall = memBus.memReq & ~memBus.memAck;

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= nextState_s;
    end
  end

  // Hold the access and its write-back control while waiting for ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      busyAddr_r          <= {DATA_W{1'b0}};
      busyWdata_r         <= {DATA_W{1'b0}};
      busyWe_r            <= 1'b0;
      busyMemToReg_r      <= 1'b0;
      busyRegWrite_r      <= 1'b0;
      busyWriteRegister_r <= {REG_W{1'b0}};
    end else if (latch_s) begin
      busyAddr_r          <= inResult;
      busyWdata_r         <= inReadRegister2;
      busyWe_r            <= inMemWrite;
      busyMemToReg_r      <= inMemToReg;
      busyRegWrite_r      <= inRegWrite;
      busyWriteRegister_r <= inWriteRegister;
    end else begin
      busyAddr_r          <= busyAddr_r;
      busyWdata_r         <= busyWdata_r;
      busyWe_r            <= busyWe_r;
      busyMemToReg_r      <= busyMemToReg_r;
      busyRegWrite_r      <= busyRegWrite_r;
      busyWriteRegister_r <= busyWriteRegister_r;
    end
  end

  // One-cycle status pulses, aligned with the bubble they accompany.
  always_ff @(posedge clock) begin
    if (reset) begin
      misalign_r <= 1'b0;
      error_r    <= 1'b0;
    end else begin
      misalign_r <= misalign_s;
      error_r    <= abort_s;
    end
  end

  assign memMisalign = misalign_r;
  assign memError    = error_r;

  mem_wb #(
    .DATA_W (DATA_W),
    .REG_W  (REG_W)
  ) uMemWb (
    .clock            (clock),
    .reset            (reset),
    .loadBubble       (wbBubble_s),
    .inReadData       (wbReadData_s),
    .inResult         (wbResult_s),
    .inMemToReg       (wbMemToReg_s),
    .inRegWrite       (wbRegWrite_s),
    .inWriteRegister  (wbWriteRegister_s),
    .outReadData      (outReadData),
    .outResult        (outResult),
    .outMemToReg      (outMemToReg),
    .outRegWrite      (outRegWrite),
    .outWriteRegister (outWriteRegister)
  );

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access stage of the five-stage pipeline: consumes the EX/MEM pipeline register outputs, performs loads and stores over a req/ack data-memory bus, and drives the MEM/WB pipeline register. It sits between the EX/MEM register and write-back. It raises `stall` to freeze the upstream stages while a memory access is outstanding, and inserts write-back bubbles for aborted or misaligned accesses.

## Interface
- `DATA_W`, 32, data/address width
- `REG_W`, 5, register-index width
- `TIMEOUT_CYCLES`, 255, wait-cycle limit before abort (used only with `MEM_TIMEOUT_EN`)

- `clock` in 1: sole clock, posedge
- `reset` in 1: synchronous, active-high
- `inResult` in DATA_W: ALU result; byte address for memory ops
- `inReadRegister2` in DATA_W: store data
- `inMemRead`, `inMemWrite`, `inMemToReg`, `inRegWrite` in 1 each: control bits from EX/MEM
- `inWriteRegister` in REG_W: destination register
- `memReq` out 1: bus request
- `memWe` out 1: 1 = store, 0 = load
- `memAddr` out DATA_W: word-aligned address
- `memWdata` out DATA_W: store data
- `memAck` in 1: access complete; `memRdata` valid in the same cycle
- `memRdata` in DATA_W: load data
- `stall` out 1: hold PC, IF/ID, ID/EX and EX/MEM this cycle
- `outReadData`, `outResult` out DATA_W: to write-back
- `outMemToReg`, `outRegWrite` out 1 each
- `outWriteRegister` out REG_W
- `memMisalign` out 1: one-cycle pulse on a misaligned access
- `memError` out 1: one-cycle pulse on a timeout abort

## Operation
- FSM states: IDLE, BUSY.
- An instruction is a memory op when `inMemRead | inMemWrite`. If both bits are set, the op is a store.
- Non-memory op in IDLE: the MEM/WB register loads the `in*` fields at the next edge; `outReadData` = 0.
- Aligned memory op in IDLE (`inResult[1:0]==0`):
  - `memReq`=1 combinationally; `memAddr`/`memWdata`/`memWe` driven straight from the inputs.
  - If `memAck` arrives the same cycle, the access completes with no stall.
  - Otherwise: latch address, data, write flag and WB control; go to BUSY.
- BUSY:
  - `memReq`=1; bus signals driven from the latched copies.
  - On `memAck`: load MEM/WB from the latched control. `outReadData` = `memRdata` for a load, 0 for a store. Return to IDLE.
- `stall` = `memReq & ~memAck`.
- Every stall cycle writes a bubble into MEM/WB: `outRegWrite`=0, `outMemToReg`=0, other fields 0.
- Misaligned memory op:
  - No request is issued.
  - MEM/WB gets a bubble; `memMisalign` pulses for one cycle.
  - No stall; the pipeline advances.
- `memAck` while no request is outstanding is ignored.

## Timing
- Reset values: every output is 0 and the state is IDLE. Reset takes effect at the next edge.
- Reset mid-access: `memReq` drops in the cycle after reset is sampled; the pending access is discarded with no write-back.
- Latency:
  - Non-memory op: 1 cycle to MEM/WB.
  - Zero-wait memory: 1 cycle.
  - N wait cycles: N+1 cycles to MEM/WB, with `stall` high for N cycles.
- Back-to-back memory ops: the second request is issued in the cycle after the first one's ack; there is no idle gap.
- `memMisalign` and `memError` are registered outputs and are high for exactly one cycle.

## Configuration
- `MEM_TIMEOUT_EN` defined:
  - A wait counter clears on entry to BUSY and increments each BUSY cycle without ack.
  - On the cycle the count reaches `TIMEOUT_CYCLES`, the access aborts: `memReq` drops next cycle, MEM/WB gets a bubble, `memError` pulses, and the FSM returns to IDLE.
  - An ack that arrives in the abort cycle wins; there is no error.
- `MEM_TIMEOUT_EN` undefined: no counter; BUSY waits indefinitely; `memError` is tied to 0.

## Structure
- Shared package `mem_pkg`:
  - FSM state enum (IDLE, BUSY)
  - `DATA_W`/`REG_W` defaults
  - bubble constant for the MEM/WB control fields
- Sub-module `mem_wb`: the MEM/WB pipeline register (sync reset, load-bubble input). It is instantiated once here.

## Test plan
- ALU op, `inResult`=0x1234, `inRegWrite`=1, `inWriteRegister`=5 -> next cycle `outResult`=0x1234, `outRegWrite`=1, `outWriteRegister`=5, `stall` never high.
- Load at 0x100 with zero-wait memory, `memRdata`=0xDEADBEEF -> `memReq` for 1 cycle, no stall, `outReadData`=0xDEADBEEF next cycle.
- Store to 0x200 with data 0xCAFE and ack after 3 wait cycles -> `stall` high 3 cycles, `memWe`=1, `memAddr`/`memWdata` stable throughout, 3 bubbles then the store's WB entry with `outReadData`=0.
- Load at 0x102 -> `memReq` stays 0, `memMisalign` pulses once, bubble in MEM/WB, no stall.
- `MEM_TIMEOUT_EN` with `TIMEOUT_CYCLES`=4 and no ack -> `memError` pulses after 4 BUSY cycles, `memReq` drops, FSM back in IDLE; same case without the macro -> `stall` remains high.
- `reset` asserted on the 2nd wait cycle -> `memReq`=0 and all outputs 0 next cycle; a following load completes normally.
